// File: rtl/code_receive.sv
// code_receive: UART-style serial code receiver.
// Frame: one start bit (0), eight data bits MSB first, one stop bit (1).
// Every bit lasts BIT_CYCLES clocks. The line is synchronized first and then
// sampled at the middle of each bit. The sample point is found by counting
// half a bit period from the falling edge of the start bit, and one full bit
// period after that for each later bit.
module code_receive #(
   parameter int BIT_CYCLES = 12500
) (
   input  logic       CLOCK_50,
   input  logic       reset_n,
   input  logic       serial_in,
   output logic [7:0] code_out,
   output logic       code_valid,
   output logic       frame_err,
   output logic       busy
);

   localparam int CNT_W = $clog2(BIT_CYCLES);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BIT_CYCLES / 2 - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       bit_idx_q, bit_idx_d;
   logic [7:0]       shift_q, shift_d;
   logic [7:0]       code_q, code_d;
   logic             valid_q, valid_d;
   logic             err_q, err_d;
   logic             busy_q;

   // Two-flop synchronizer plus the previous synchronized value for edge detection.
   logic sync1_q, sync2_q, s_prev_q;
   logic s;
   logic fall;

   assign s    = sync2_q;
   assign fall = s_prev_q & ~s;

   // Synchronizer and edge-history flops. All of them idle high, so the
   // first frame after reset still needs a real high-to-low transition.
   // The edge history keeps updating in every state. A line that is still
   // low when the block returns to IDLE therefore cannot start a new frame.
   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q  <= 1'b1;
         sync2_q  <= 1'b1;
         s_prev_q <= 1'b1;
      end else begin
         sync1_q  <= serial_in;
         sync2_q  <= sync1_q;
         s_prev_q <= sync2_q;
      end
   end

   // Receiver state, datapath and output registers.
   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         bit_idx_q <= 3'd0;
         shift_q   <= 8'h00;
         code_q    <= 8'h00;
         valid_q   <= 1'b0;
         err_q     <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bit_idx_q <= bit_idx_d;
         shift_q   <= shift_d;
         code_q    <= code_d;
         valid_q   <= valid_d;
         err_q     <= err_d;
         // Decoding the next state keeps busy aligned with state_q.
         busy_q    <= (state_d != IDLE);
      end
   end

   // Next-state and datapath logic. Edges on s are only looked at in IDLE.
   // Every other state acts only at its scheduled sample point.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      code_d    = code_q;
      valid_d   = 1'b0;
      err_d     = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (fall) begin
               state_d = START;
               cnt_d   = '0;
            end
         end

         START: begin
            if (cnt_q == HALF_LAST) begin
               cnt_d = '0;
               if (!s) begin
                  state_d   = DATA;
                  bit_idx_d = 3'd0;
               end else begin
                  // The line was already high again at mid start bit:
                  // treat it as a glitch and drop it silently.
                  state_d = IDLE;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         DATA: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d     = '0;
               shift_d   = {shift_q[6:0], s};
               bit_idx_d = bit_idx_q + 3'd1;
               if (bit_idx_q == 3'd7) begin
                  state_d = STOP;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         STOP: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d   = '0;
               state_d = IDLE;
               if (s) begin
                  code_d  = shift_q;
                  valid_d = 1'b1;
               end else begin
                  err_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   assign code_out   = code_q;
   assign code_valid = valid_q;
   assign frame_err  = err_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_code_receive.sv
// Directed testbench for code_receive with BIT_CYCLES = 16.
// A table of single frames is followed by hand-written sequences: a glitch,
// a bad stop bit with the line held low, back-to-back frames, and a reset
// in the middle of a frame.
module tb_code_receive;

   localparam int BC = 16;

   logic       clk;
   logic       reset_n;
   logic       serial_in;
   logic [7:0] code_out;
   logic       code_valid;
   logic       frame_err;
   logic       busy;

   code_receive #(.BIT_CYCLES(BC)) dut (
      .CLOCK_50  (clk),
      .reset_n   (reset_n),
      .serial_in (serial_in),
      .code_out  (code_out),
      .code_valid(code_valid),
      .frame_err (frame_err),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Monitor state, sampled on the falling edge.
   int         cyc = 0;
   int         valid_cnt = 0;
   int         err_cnt = 0;
   int         both_cnt = 0;
   int         busy_rises = 0;
   int         start_cyc = 0;
   int         valid_cyc = 0;
   int         valid_cyc_prev = 0;
   logic [7:0] last_code = 8'h00;
   logic [7:0] last_code_prev = 8'h00;
   logic       busy_prev = 1'b0;

   always @(negedge clk) begin
      cyc = cyc + 1;
      if (busy && !busy_prev) begin
         busy_rises = busy_rises + 1;
         start_cyc  = cyc;
      end
      busy_prev = busy;
      if (code_valid) begin
         valid_cnt      = valid_cnt + 1;
         valid_cyc_prev = valid_cyc;
         valid_cyc      = cyc;
         last_code_prev = last_code;
         last_code      = code_out;
      end
      if (frame_err) err_cnt = err_cnt + 1;
      if (code_valid && frame_err) both_cnt = both_cnt + 1;
   end

   task automatic check(input string name, input int actual, input int expected);
      checks = checks + 1;
      if (actual !== expected) begin
         errors = errors + 1;
         $display("FAIL %s: actual=%0d (0x%0h) expected=%0d (0x%0h)",
                  name, actual, actual, expected, expected);
      end else begin
         $display("ok   %s: %0d (0x%0h)", name, actual, actual);
      end
   endtask

   task automatic clear_counts();
      valid_cnt  = 0;
      err_cnt    = 0;
      busy_rises = 0;
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic drive_bit(input logic b);
      serial_in = b;
      wait_cycles(BC);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop);
      drive_bit(1'b0);
      for (int i = 7; i >= 0; i--) drive_bit(d[i]);
      drive_bit(stop);
   endtask

   typedef struct {
      logic [7:0] data;
      logic       stop;
      int         exp_valid;
      int         exp_err;
      logic [7:0] exp_code;
   } vec_t;

   vec_t vecs [5];

   initial begin
      vecs[0] = '{data: 8'hA5, stop: 1'b1, exp_valid: 1, exp_err: 0, exp_code: 8'hA5};
      vecs[1] = '{data: 8'h3C, stop: 1'b0, exp_valid: 0, exp_err: 1, exp_code: 8'hA5};
      vecs[2] = '{data: 8'h00, stop: 1'b1, exp_valid: 1, exp_err: 0, exp_code: 8'h00};
      vecs[3] = '{data: 8'hFF, stop: 1'b1, exp_valid: 1, exp_err: 0, exp_code: 8'hFF};
      vecs[4] = '{data: 8'h5A, stop: 1'b0, exp_valid: 0, exp_err: 1, exp_code: 8'hFF};

      serial_in = 1'b1;
      reset_n   = 1'b0;
      wait_cycles(3);
      check("reset code_out",   code_out,   8'h00);
      check("reset code_valid", code_valid, 0);
      check("reset frame_err",  frame_err,  0);
      check("reset busy",       busy,       0);
      reset_n = 1'b1;
      wait_cycles(10);
      check("idle busy after reset", busy, 0);

      // Table of single frames.
      for (int v = 0; v < 5; v++) begin
         clear_counts();
         send_frame(vecs[v].data, vecs[v].stop);
         serial_in = 1'b1;
         wait_cycles(40);
         $display("frame %0d data=0x%0h stop=%0d code_out=0x%0h", v,
                  vecs[v].data, vecs[v].stop, code_out);
         check($sformatf("vec%0d valid count", v), valid_cnt, vecs[v].exp_valid);
         check($sformatf("vec%0d err count", v),   err_cnt,   vecs[v].exp_err);
         check($sformatf("vec%0d code_out", v),    code_out,  vecs[v].exp_code);
         check($sformatf("vec%0d busy after", v),  busy,      0);
         if (vecs[v].exp_valid == 1)
            check($sformatf("vec%0d latency", v), valid_cyc - start_cyc, 152);
      end

      // The start bit is only 4 cycles long, so it is gone by the mid-start sample.
      clear_counts();
      serial_in = 1'b0;
      wait_cycles(4);
      serial_in = 1'b1;
      wait_cycles(30);
      check("glitch entered start", busy_rises, 1);
      check("glitch valid count",   valid_cnt,  0);
      check("glitch err count",     err_cnt,    0);
      check("glitch busy",          busy,       0);
      check("glitch code_out",      code_out,   8'hFF);

      // A bad stop bit, with the line then held low, must not retrigger.
      clear_counts();
      send_frame(8'h3C, 1'b0);
      wait_cycles(100);
      check("hold-low err count",  err_cnt,    1);
      check("hold-low valid",      valid_cnt,  0);
      check("hold-low busy rises", busy_rises, 1);
      check("hold-low code_out",   code_out,   8'hFF);
      serial_in = 1'b1;
      wait_cycles(40);
      check("release busy rises",  busy_rises, 1);

      // Back-to-back frames with no idle gap.
      clear_counts();
      send_frame(8'h3C, 1'b1);
      send_frame(8'hC3, 1'b1);
      serial_in = 1'b1;
      wait_cycles(40);
      check("b2b valid count",  valid_cnt,                  2);
      check("b2b spacing",      valid_cyc - valid_cyc_prev, 160);
      check("b2b first code",   last_code_prev,             8'h3C);
      check("b2b second code",  last_code,                  8'hC3);
      check("b2b err count",    err_cnt,                    0);

      // Reset halfway through data bit 4 of a frame.
      clear_counts();
      drive_bit(1'b0);
      drive_bit(1'b1);
      drive_bit(1'b1);
      drive_bit(1'b1);
      drive_bit(1'b1);
      serial_in = 1'b0;
      wait_cycles(8);
      check("pre-reset busy", busy, 1);
      #2 reset_n = 1'b0;
      #1;
      check("async reset code_out", code_out,   8'h00);
      check("async reset valid",    code_valid, 0);
      check("async reset err",      frame_err,  0);
      check("async reset busy",     busy,       0);
      wait_cycles(3);
      serial_in = 1'b1;
      reset_n   = 1'b1;
      wait_cycles(200);
      check("post-reset valid count", valid_cnt, 0);
      check("post-reset err count",   err_cnt,   0);
      check("post-reset busy",        busy,      0);
      clear_counts();
      send_frame(8'h81, 1'b1);
      wait_cycles(40);
      check("after reset valid count", valid_cnt,             1);
      check("after reset code_out",    code_out,              8'h81);
      check("after reset latency",     valid_cyc - start_cyc, 152);

      check("valid and err together", both_cnt, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
